// File: rtl/tag_port_rr_ctrl_pkg.sv
// Shared types and widths for the D$ tag-port round-robin controller.
// Contents: arb_state_e (arbiter FSM states), PERF_CNT_WIDTH, DCACHE_TAG_WIDTH.
package tag_port_rr_ctrl_pkg;

    localparam int unsigned PERF_CNT_WIDTH   = 16;
    localparam int unsigned DCACHE_TAG_WIDTH = 44;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_WAIT   = 2'd1,
        ARB_LOCKED = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_prio_pick.sv
// Round-robin priority picker: first set request at or after ptr_i, wrapping.
// Ports: req_i (request vector), ptr_i (start index),
//        oh_o (one-hot winner), idx_o (winner index), valid_o (any request).
module rr_prio_pick #(
    parameter int unsigned NR_PORTS = 3,
    parameter int unsigned IDX_W    = 2
) (
    input  logic [NR_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]    ptr_i,
    output logic [NR_PORTS-1:0] oh_o,
    output logic [IDX_W-1:0]    idx_o,
    output logic                valid_o
);

    int unsigned cand;

    // Scan NR_PORTS candidates starting at ptr_i; first hit wins.
    always_comb begin
        oh_o    = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int unsigned k = 0; k < NR_PORTS; k++) begin
            cand = (32'(ptr_i) + k) % NR_PORTS;
            if (!valid_o && req_i[IDX_W'(cand)]) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(cand);
            end
        end
        oh_o[idx_o] = valid_o;
    end

endmodule

// File: rtl/tag_port_rr_ctrl.sv
// Round-robin arbiter/sequencer sharing the D$ tag/data port among NR_PORTS
// requesters; holds ownership across locked sequences and returns the late
// tag-compare hit vector to the owning port one cycle after a read accept.
// Ports: clk_i, rst_i (async, active-high), clr_i (sync flush);
//        req_i/lock_i/addr_i/we_i/tag_i per-port inputs; gnt_o, rvalid_o,
//        hit_way_o, multihit_o responses; mem_req_o/mem_gnt_i/mem_addr_o/
//        mem_we_o/mem_tag_i/mem_valid_i memory side; perf_conflict_o counters.
// Build option: define TAG_PORT_RR_PERF_EN to enable the per-port
// lost-arbitration counters; otherwise perf_conflict_o is tied to zero.
module tag_port_rr_ctrl
    import tag_port_rr_ctrl_pkg::*;
#(
    parameter int unsigned NR_PORTS         = 3,
    parameter int unsigned ADDR_WIDTH       = 12,
    parameter int unsigned DCACHE_SET_ASSOC = 8,
    parameter int unsigned TAG_WIDTH        = DCACHE_TAG_WIDTH
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 clr_i,
    input  logic [NR_PORTS-1:0]                  req_i,
    input  logic [NR_PORTS-1:0]                  lock_i,
    input  logic [NR_PORTS*ADDR_WIDTH-1:0]       addr_i,
    input  logic [NR_PORTS-1:0]                  we_i,
    input  logic [NR_PORTS*TAG_WIDTH-1:0]        tag_i,
    output logic [NR_PORTS-1:0]                  gnt_o,
    output logic [NR_PORTS-1:0]                  rvalid_o,
    output logic [DCACHE_SET_ASSOC-1:0]          hit_way_o,
    output logic                                 multihit_o,
    output logic                                 mem_req_o,
    input  logic                                 mem_gnt_i,
    output logic [ADDR_WIDTH-1:0]                mem_addr_o,
    output logic                                 mem_we_o,
    input  logic [DCACHE_SET_ASSOC*TAG_WIDTH-1:0] mem_tag_i,
    input  logic [DCACHE_SET_ASSOC-1:0]          mem_valid_i,
    output logic [NR_PORTS*PERF_CNT_WIDTH-1:0]   perf_conflict_o
);

    localparam int unsigned IDX_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] hold_id_q, hold_id_d;   // frozen winner (WAIT) or owner (LOCKED)
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDX_W-1:0] rsp_id_q, rsp_id_d;

    logic [NR_PORTS-1:0] pick_oh;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_valid;
    logic [IDX_W-1:0]    win_id;
    logic                win_req;
    logic                accept;

    logic [ADDR_WIDTH-1:0] addr_arr    [NR_PORTS];
    logic [TAG_WIDTH-1:0]  tag_arr     [NR_PORTS];
    logic [TAG_WIDTH-1:0]  way_tag_arr [DCACHE_SET_ASSOC];

    // Unpack flat per-port / per-way buses.
    for (genvar p = 0; p < NR_PORTS; p++) begin : g_port
        assign addr_arr[p] = addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign tag_arr[p]  = tag_i[p*TAG_WIDTH +: TAG_WIDTH];
    end
    for (genvar w = 0; w < DCACHE_SET_ASSOC; w++) begin : g_way
        assign way_tag_arr[w] = mem_tag_i[w*TAG_WIDTH +: TAG_WIDTH];
    end

    rr_prio_pick #(
        .NR_PORTS (NR_PORTS),
        .IDX_W    (IDX_W)
    ) u_pick (
        .req_i   (req_i),
        .ptr_i   (rr_ptr_q),
        .oh_o    (pick_oh),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // Arbitration FSM: next state, memory request and grant.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        hold_id_d   = hold_id_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        win_id      = '0;
        win_req     = 1'b0;
        gnt_o       = '0;
        mem_req_o   = 1'b0;
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                win_id  = pick_idx;
                win_req = pick_valid && (pick_oh != '0);
            end
            ARB_WAIT: begin
                win_id  = hold_id_q;
                win_req = 1'b1;
            end
            ARB_LOCKED: begin
                win_id  = hold_id_q;
                win_req = req_i[hold_id_q];
            end
            default: ;
        endcase

        // A flush suppresses any request in the same cycle.
        if (clr_i) begin
            win_req = 1'b0;
        end
        accept = win_req && mem_gnt_i;

        if (win_req) begin
            mem_req_o  = 1'b1;
            mem_addr_o = addr_arr[win_id];
            mem_we_o   = we_i[win_id];
        end
        if (accept) begin
            gnt_o[win_id] = 1'b1;
        end

        if (accept) begin
            rsp_valid_d = !we_i[win_id];
            rsp_id_d    = win_id;
            if (state_q != ARB_LOCKED) begin
                rr_ptr_d = (win_id == IDX_W'(NR_PORTS - 1)) ? '0 : win_id + IDX_W'(1);
            end
            if (lock_i[win_id]) begin
                state_d   = ARB_LOCKED;
                hold_id_d = win_id;
            end else begin
                state_d = ARB_IDLE;
            end
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (win_req) begin
                        state_d   = ARB_WAIT;
                        hold_id_d = win_id;
                    end
                end
                ARB_LOCKED: begin
                    if (!req_i[hold_id_q] && !lock_i[hold_id_q]) begin
                        state_d = ARB_IDLE;
                    end
                end
                default: ;
            endcase
        end

        if (clr_i) begin
            state_d     = ARB_IDLE;
            rr_ptr_d    = '0;
            hold_id_d   = '0;
            rsp_valid_d = 1'b0;
            rsp_id_d    = '0;
        end
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            hold_id_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_id_q   <= hold_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    // Late tag compare for the read accepted in the previous cycle.
    always_comb begin
        rvalid_o  = '0;
        hit_way_o = '0;
        if (rsp_valid_q) begin
            rvalid_o[rsp_id_q] = 1'b1;
            for (int unsigned j = 0; j < DCACHE_SET_ASSOC; j++) begin
                hit_way_o[j] = mem_valid_i[j] && (way_tag_arr[j] == tag_arr[rsp_id_q]);
            end
        end
        multihit_o = rsp_valid_q && ($countones(hit_way_o) > 1);
    end

`ifdef TAG_PORT_RR_PERF_EN
    logic [PERF_CNT_WIDTH-1:0] perf_q [NR_PORTS];
    logic [PERF_CNT_WIDTH-1:0] perf_d [NR_PORTS];

    // Saturating count of cycles each port requested but was not granted.
    always_comb begin
        for (int unsigned p = 0; p < NR_PORTS; p++) begin
            perf_d[p] = perf_q[p];
            if (clr_i) begin
                perf_d[p] = '0;
            end else if (req_i[p] && !gnt_o[p] && (perf_q[p] != '1)) begin
                perf_d[p] = perf_q[p] + PERF_CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned p = 0; p < NR_PORTS; p++) begin
                perf_q[p] <= '0;
            end
        end else begin
            for (int unsigned p = 0; p < NR_PORTS; p++) begin
                perf_q[p] <= perf_d[p];
            end
        end
    end

    for (genvar p = 0; p < NR_PORTS; p++) begin : g_perf
        assign perf_conflict_o[p*PERF_CNT_WIDTH +: PERF_CNT_WIDTH] = perf_q[p];
    end
`else
    assign perf_conflict_o = '0;
`endif

endmodule

// File: tb/tb_tag_port_rr_ctrl.sv
// Directed bench for tag_port_rr_ctrl: round-robin order, late hit response,
// WAIT freeze, locked ownership, multihit, reset mid-WAIT and perf counters.
module tb_tag_port_rr_ctrl;

    localparam int unsigned NP = 3;
    localparam int unsigned AW = 12;
    localparam int unsigned SA = 8;
    localparam int unsigned TW = 44;
    localparam int unsigned PW = 16;

`ifdef TAG_PORT_RR_PERF_EN
    localparam logic [PW-1:0] PERF_EXP = 16'd2;
`else
    localparam logic [PW-1:0] PERF_EXP = 16'd0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_i, clr_i;
    logic [NP-1:0]     req_i, lock_i, we_i;
    logic [NP*AW-1:0]  addr_i;
    logic [NP*TW-1:0]  tag_i;
    logic [NP-1:0]     gnt_o, rvalid_o;
    logic [SA-1:0]     hit_way_o;
    logic              multihit_o, mem_req_o, mem_gnt_i, mem_we_o;
    logic [AW-1:0]     mem_addr_o;
    logic [SA*TW-1:0]  mem_tag_i;
    logic [SA-1:0]     mem_valid_i;
    logic [NP*PW-1:0]  perf_conflict_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    tag_port_rr_ctrl #(
        .NR_PORTS         (NP),
        .ADDR_WIDTH       (AW),
        .DCACHE_SET_ASSOC (SA),
        .TAG_WIDTH        (TW)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .clr_i           (clr_i),
        .req_i           (req_i),
        .lock_i          (lock_i),
        .addr_i          (addr_i),
        .we_i            (we_i),
        .tag_i           (tag_i),
        .gnt_o           (gnt_o),
        .rvalid_o        (rvalid_o),
        .hit_way_o       (hit_way_o),
        .multihit_o      (multihit_o),
        .mem_req_o       (mem_req_o),
        .mem_gnt_i       (mem_gnt_i),
        .mem_addr_o      (mem_addr_o),
        .mem_we_o        (mem_we_o),
        .mem_tag_i       (mem_tag_i),
        .mem_valid_i     (mem_valid_i),
        .perf_conflict_o (perf_conflict_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input int p, input logic [AW-1:0] a);
        addr_i[p*AW +: AW] = a;
    endtask

    task automatic set_tag(input int p, input logic [TW-1:0] t);
        tag_i[p*TW +: TW] = t;
    endtask

    task automatic set_way(input int w, input logic [TW-1:0] t);
        mem_tag_i[w*TW +: TW] = t;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1; clr_i = 1'b0; req_i = '0; lock_i = '0; we_i = '0;
        addr_i = '0; tag_i = '0; mem_gnt_i = 1'b0; mem_tag_i = '0; mem_valid_i = '0;
        set_addr(0, 12'h100);
        set_addr(1, 12'h111);
        set_addr(2, 12'h222);

        // Reset state
        @(negedge clk_i); #1;
        chk("rst_gnt", 64'(gnt_o), 64'h0);
        chk("rst_mem_req", 64'(mem_req_o), 64'h0);
        chk("rst_rvalid", 64'(rvalid_o), 64'h0);
        chk("rst_perf", 64'(perf_conflict_o), 64'h0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // All three request, memory always accepts: 0,1,2,0
        req_i = 3'b111; we_i = 3'b111; mem_gnt_i = 1'b1;
        #1;
        chk("rr_gnt_a", 64'(gnt_o), 64'h1);
        chk("rr_addr_a", 64'(mem_addr_o), 64'h100);
        chk("rr_we_a", 64'(mem_we_o), 64'h1);
        @(negedge clk_i); #1;
        chk("rr_gnt_b", 64'(gnt_o), 64'h2);
        chk("rr_addr_b", 64'(mem_addr_o), 64'h111);
        @(negedge clk_i); #1;
        chk("rr_gnt_c", 64'(gnt_o), 64'h4);
        chk("rr_addr_c", 64'(mem_addr_o), 64'h222);
        @(negedge clk_i); #1;
        chk("rr_gnt_d", 64'(gnt_o), 64'h1);
        @(negedge clk_i);
        req_i = '0;
        #1;
        chk("write_no_rvalid", 64'(rvalid_o), 64'h0);
        chk("idle_mem_req", 64'(mem_req_o), 64'h0);

        // Port1 read, hit on way5 (rr_ptr now 1)
        @(negedge clk_i);
        req_i = 3'b010; we_i = 3'b000; set_tag(1, 44'h2A);
        #1;
        chk("hit_gnt", 64'(gnt_o), 64'h2);
        @(negedge clk_i);
        req_i = '0; mem_valid_i = 8'h20; set_way(5, 44'h2A);
        #1;
        chk("hit_rvalid", 64'(rvalid_o), 64'h2);
        chk("hit_way", 64'(hit_way_o), 64'h20);
        chk("hit_multihit", 64'(multihit_o), 64'h0);

        // Port1 read again (pointer wraps from 2), then multihit on ways 1,3
        @(negedge clk_i);
        req_i = 3'b010; mem_valid_i = '0;
        #1;
        chk("wrap_gnt", 64'(gnt_o), 64'h2);
        @(negedge clk_i);
        req_i = 3'b001; mem_valid_i = 8'hFF;
        set_way(5, 44'h0); set_way(1, 44'h2A); set_way(3, 44'h2A);
        #1;
        chk("mh_rvalid", 64'(rvalid_o), 64'h2);
        chk("mh_way", 64'(hit_way_o), 64'h0A);
        chk("mh_flag", 64'(multihit_o), 64'h1);
        chk("b2b_gnt", 64'(gnt_o), 64'h1);
        @(negedge clk_i);
        req_i = '0; set_tag(0, 44'h33); set_way(7, 44'h33);
        #1;
        chk("b2b_rvalid", 64'(rvalid_o), 64'h1);
        chk("b2b_way", 64'(hit_way_o), 64'h80);
        chk("b2b_multihit", 64'(multihit_o), 64'h0);
        @(negedge clk_i);
        mem_valid_i = '0;
        #1;
        chk("rsp_done", 64'(rvalid_o), 64'h0);

        // Port2 stalls 3 cycles while port0 rises: winner frozen
        req_i = 3'b100; mem_gnt_i = 1'b0;
        #1;
        chk("wait_req_1", 64'(mem_req_o), 64'h1);
        chk("wait_addr_1", 64'(mem_addr_o), 64'h222);
        chk("wait_gnt_1", 64'(gnt_o), 64'h0);
        @(negedge clk_i);
        req_i = 3'b101;
        #1;
        chk("wait_addr_2", 64'(mem_addr_o), 64'h222);
        chk("wait_gnt_2", 64'(gnt_o), 64'h0);
        @(negedge clk_i); #1;
        chk("wait_addr_3", 64'(mem_addr_o), 64'h222);
        chk("wait_gnt_3", 64'(gnt_o), 64'h0);
        @(negedge clk_i);
        mem_gnt_i = 1'b1;
        #1;
        chk("wait_gnt_4", 64'(gnt_o), 64'h4);
        chk("wait_addr_4", 64'(mem_addr_o), 64'h222);
        @(negedge clk_i);
        req_i = 3'b001;
        #1;
        chk("after_wait_gnt", 64'(gnt_o), 64'h1);
        chk("after_wait_rvalid", 64'(rvalid_o), 64'h4);
        @(negedge clk_i);
        req_i = '0; clr_i = 1'b1;
        @(negedge clk_i);
        clr_i = 1'b0;

        // Port0 locked for 4 beats; port1 starved until lock drops
        req_i = 3'b011; lock_i = 3'b001; we_i = 3'b011;
        #1;
        chk("lock_beat_1", 64'(gnt_o), 64'h1);
        for (int b = 2; b <= 4; b++) begin
            @(negedge clk_i); #1;
            chk("lock_beat_n", 64'(gnt_o), 64'h1);
        end
        @(negedge clk_i);
        req_i = 3'b010; lock_i = '0;
        #1;
        chk("lock_release_gnt", 64'(gnt_o), 64'h0);
        chk("lock_release_req", 64'(mem_req_o), 64'h0);
        @(negedge clk_i); #1;
        chk("lock_port1_gnt", 64'(gnt_o), 64'h2);

        // Reset while in WAIT with a pending read response
        @(negedge clk_i);
        req_i = 3'b001; we_i = '0; mem_gnt_i = 1'b1;
        #1;
        chk("prerst_gnt", 64'(gnt_o), 64'h1);
        @(negedge clk_i);
        req_i = 3'b100; mem_gnt_i = 1'b0;
        #1;
        chk("prerst_rvalid", 64'(rvalid_o), 64'h1);
        chk("prerst_req", 64'(mem_req_o), 64'h1);
        @(negedge clk_i); #1;
        chk("prerst_wait_gnt", 64'(gnt_o), 64'h0);
        rst_i = 1'b1; req_i = '0;
        #1;
        chk("midrst_req", 64'(mem_req_o), 64'h0);
        chk("midrst_gnt", 64'(gnt_o), 64'h0);
        chk("midrst_rvalid", 64'(rvalid_o), 64'h0);
        chk("midrst_addr", 64'(mem_addr_o), 64'h0);
        chk("midrst_we", 64'(mem_we_o), 64'h0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Port2 loses two cycles, then is granted
        req_i = 3'b100; mem_gnt_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        mem_gnt_i = 1'b1;
        #1;
        chk("perf_gnt", 64'(gnt_o), 64'h4);
        @(negedge clk_i);
        req_i = '0;
        #1;
        chk("perf_port2", 64'(perf_conflict_o[2*PW +: PW]), 64'(PERF_EXP));
        chk("perf_port0_1", 64'(perf_conflict_o[0 +: 2*PW]), 64'h0);

        // Flush suppresses request and clears counters
        @(negedge clk_i);
        clr_i = 1'b1; req_i = 3'b100;
        #1;
        chk("clr_mem_req", 64'(mem_req_o), 64'h0);
        chk("clr_gnt", 64'(gnt_o), 64'h0);
        @(negedge clk_i);
        clr_i = 1'b0; req_i = '0;
        #1;
        chk("clr_perf", 64'(perf_conflict_o), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
